// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter: FSM states, master indices
// and the state-to-grant encoding.
package wb_arb_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    OWN0 = 3'd1,
    OWN1 = 3'd2,
    TO0  = 3'd3,
    TO1  = 3'd4
  } arb_state_e;

  localparam int M0 = 0;
  localparam int M1 = 1;

  // The grant stays with the owner through its abort cycle.
  function automatic logic [1:0] grant_of(arb_state_e s);
    logic [1:0] g;
    g = 2'b00;
    case (s)
      OWN0, TO0: g[M0] = 1'b1;
      OWN1, TO1: g[M1] = 1'b1;
      default:   g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Bus watchdog: counts consecutive unanswered strobe cycles and flags expiry.
// A TIMEOUT of 0 disables it.
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          hit;

  // A termination on the final cycle wins over the abort.
  assign hit      = (TIMEOUT > 0) && en_i && !clr_i && (cnt_q == LAST);
  assign expire_o = hit;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || hit || (TIMEOUT == 0)) cnt_d = '0;
    else if (en_i)                      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wb_bus_arbiter_2m.sv
// Two-master Wishbone classic arbiter: round-robin, grant held for a whole CYC,
// silent slave turned into ERR by the watchdog.
//   state | meaning
//   IDLE  | no owner, slave port quiet
//   OWN0  | m0 owns the slave port
//   OWN1  | m1 owns the slave port
//   TO0   | one-cycle watchdog abort to m0
//   TO1   | one-cycle watchdog abort to m1
module wb_bus_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255,
  localparam int SW     = DW / 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [SW-1:0] m0_sel_i,
  input  logic [DW-1:0] m0_dat_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  output logic          m0_rty_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [SW-1:0] m1_sel_i,
  input  logic [DW-1:0] m1_dat_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic          m1_rty_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [AW-1:0] s_adr_o,
  output logic [SW-1:0] s_sel_o,
  output logic [DW-1:0] s_dat_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  input  logic          s_err_i,
  input  logic          s_rty_i,
  output logic [1:0]    grant_o,
  output logic          timeout_o
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       stb_own, ack_t, err_t, rty_t, wd_expire;

  always_comb begin
    stb_own = 1'b0;
    if (state_q == OWN0)      stb_own = m0_stb_i;
    else if (state_q == OWN1) stb_own = m1_stb_i;
  end

  // Slave protocol violations resolve as ack > err > rty.
  assign ack_t = s_ack_i & stb_own;
  assign err_t = s_err_i & stb_own & ~s_ack_i;
  assign rty_t = s_rty_i & stb_own & ~s_ack_i & ~s_err_i;

  wb_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .clr_i    (~stb_own | s_ack_i | s_err_i | s_rty_i),
    .en_i     (stb_own),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_q ? OWN0 : OWN1;
        else if (m0_cyc_i)        state_d = OWN0;
        else if (m1_cyc_i)        state_d = OWN1;
      end
      OWN0, TO0: begin
        if (!m0_cyc_i) begin
          last_d  = 1'b0;
          state_d = m1_cyc_i ? OWN1 : IDLE;
        end else if (state_q == TO0) state_d = OWN0;
        else if (wd_expire)          state_d = TO0;
      end
      OWN1, TO1: begin
        if (!m1_cyc_i) begin
          last_d  = 1'b1;
          state_d = m0_cyc_i ? OWN0 : IDLE;
        end else if (state_q == TO1) state_d = OWN1;
        else if (wd_expire)          state_d = TO1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_adr_o   = '0;
    s_sel_o   = '0;
    s_dat_o   = '0;
    m0_dat_o  = '0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m0_rty_o  = 1'b0;
    m1_dat_o  = '0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    m1_rty_o  = 1'b0;
    timeout_o = 1'b0;
    case (state_q)
      OWN0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_sel_o  = m0_sel_i;
        s_dat_o  = m0_dat_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = ack_t;
        m0_err_o = err_t;
        m0_rty_o = rty_t;
      end
      OWN1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_sel_o  = m1_sel_i;
        s_dat_o  = m1_dat_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = ack_t;
        m1_err_o = err_t;
        m1_rty_o = rty_t;
      end
      TO0: begin
        m0_err_o  = 1'b1;
        timeout_o = 1'b1;
      end
      TO1: begin
        m1_err_o  = 1'b1;
        timeout_o = 1'b1;
      end
      default: ;
    endcase
    grant_o = grant_of(state_q);
  end

endmodule

// File: tb/tb_wb_bus_arbiter_2m.sv
// Directed self-checking bench for wb_bus_arbiter_2m with a short watchdog.
module tb_wb_bus_arbiter_2m;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic [3:0]  m0_sel_i;
  logic        m0_ack_o, m0_err_o, m0_rty_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic [3:0]  m1_sel_i;
  logic        m1_ack_o, m1_err_o, m1_rty_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_ack_i, s_err_i, s_rty_i;
  logic [1:0]  grant_o;
  logic        timeout_o;

  int n_cmp = 0;
  int n_err = 0;

  wb_bus_arbiter_2m #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  initial forever #5 wb_clk_i = ~wb_clk_i;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0] burst_adr [4] = '{32'h10, 32'h14, 32'h18, 32'h1C};

  initial begin
    wb_rst_i = 1'b1;
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_sel_i = '0; m0_dat_i = '0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_sel_i = '0; m1_dat_i = '0;
    s_dat_i = '0; s_ack_i = 0; s_err_i = 0; s_rty_i = 0;

    // reset state
    repeat (2) @(negedge wb_clk_i);
    #1;
    chk2("rst_grant", grant_o, 2'b00);
    chk1("rst_scyc", s_cyc_o, 1'b0);
    chk1("rst_timeout", timeout_o, 1'b0);
    wb_rst_i = 1'b0;

    // single read by m0
    @(negedge wb_clk_i);
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 32'h0000_0100; m0_sel_i = 4'hF;
    #1 chk1("t1_latency", s_cyc_o, 1'b0);
    @(negedge wb_clk_i);
    #1;
    chk1("t1_scyc", s_cyc_o, 1'b1);
    chk32("t1_sadr", s_adr_o, 32'h0000_0100);
    chk2("t1_grant", grant_o, 2'b01);
    chk1("t1_noack_yet", m0_ack_o, 1'b0);
    @(negedge wb_clk_i);
    s_ack_i = 1; s_dat_i = 32'hCAFE_F00D;
    #1;
    chk1("t1_m0ack", m0_ack_o, 1'b1);
    chk32("t1_m0dat", m0_dat_o, 32'hCAFE_F00D);
    chk1("t1_m1ack", m1_ack_o, 1'b0);
    chk32("t1_m1dat", m1_dat_o, 32'h0);
    @(negedge wb_clk_i);
    s_ack_i = 0; s_dat_i = '0; m0_cyc_i = 0; m0_stb_i = 0;
    #1;
    chk1("t1_scyc_drop", s_cyc_o, 1'b0);
    chk2("t1_grant_hold", grant_o, 2'b01);
    @(negedge wb_clk_i);
    #1 chk2("t1_idle", grant_o, 2'b00);

    // reset again so the tie below starts from the reset pointer
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    #1 chk2("rst2_grant", grant_o, 2'b00);
    wb_rst_i = 1'b0;

    // simultaneous request, handover without an idle bubble
    @(negedge wb_clk_i);
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h200;
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h300;
    #1 chk2("t2_idle", grant_o, 2'b00);
    @(negedge wb_clk_i);
    s_ack_i = 1;
    #1;
    chk2("t2_first", grant_o, 2'b01);
    chk32("t2_adr0", s_adr_o, 32'h200);
    chk1("t2_m0ack", m0_ack_o, 1'b1);
    chk1("t2_m1ack_blocked", m1_ack_o, 1'b0);
    @(negedge wb_clk_i);
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    #1 chk2("t2_hold_lastcycle", grant_o, 2'b01);
    @(negedge wb_clk_i);
    s_ack_i = 1;
    #1;
    chk2("t2_handover", grant_o, 2'b10);
    chk32("t2_adr1", s_adr_o, 32'h300);
    chk1("t2_m1ack", m1_ack_o, 1'b1);
    chk1("t2_m0ack_blocked", m0_ack_o, 1'b0);
    @(negedge wb_clk_i);
    s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;

    // round-robin across repeated ties: m0, m1, m0, m1
    for (int r = 0; r < 4; r++) begin
      @(negedge wb_clk_i);
      m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
      #1 chk2("rr_idle", grant_o, 2'b00);
      @(negedge wb_clk_i);
      #1 chk2("rr_winner", grant_o, (r % 2 == 0) ? 2'b01 : 2'b10);
      m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    end

    // m1 write burst with stb gaps while m0 waits
    @(negedge wb_clk_i);
    m1_cyc_i = 1; m1_stb_i = 0; m1_we_i = 1; m1_sel_i = 4'hF;
    #1 chk2("t3_idle", grant_o, 2'b00);
    for (int b = 0; b < 4; b++) begin
      @(negedge wb_clk_i);
      m0_cyc_i = 1; m0_stb_i = 1;
      m1_stb_i = 1; m1_adr_i = 32'h10 + 32'(4 * b); m1_dat_i = 32'hA000 + 32'(b);
      s_ack_i = 1;
      #1;
      chk32("t3_beat_adr", s_adr_o, burst_adr[b]);
      chk2("t3_beat_grant", grant_o, 2'b10);
      chk1("t3_beat_we", s_we_o, 1'b1);
      chk1("t3_beat_m1ack", m1_ack_o, 1'b1);
      chk1("t3_beat_m0ack", m0_ack_o, 1'b0);
      @(negedge wb_clk_i);
      m1_stb_i = 0; s_ack_i = 0;
      #1;
      chk2("t3_gap_grant", grant_o, 2'b10);
      chk1("t3_gap_stb", s_stb_o, 1'b0);
    end
    @(negedge wb_clk_i);
    m1_cyc_i = 0; m1_we_i = 0;
    #1 chk2("t3_last_cycle", grant_o, 2'b10);
    @(negedge wb_clk_i);
    #1 chk2("t3_m0_after", grant_o, 2'b01);
    @(negedge wb_clk_i);
    m0_cyc_i = 0; m0_stb_i = 0;

    // watchdog abort after 8 silent strobe cycles
    @(negedge wb_clk_i);
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h400;
    #1 chk1("t4_idle_stb", s_stb_o, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge wb_clk_i);
      #1;
      chk1("t4_wait_stb", s_stb_o, 1'b1);
      chk1("t4_wait_err", m0_err_o, 1'b0);
      chk1("t4_wait_to", timeout_o, 1'b0);
    end
    @(negedge wb_clk_i);
    s_ack_i = 1;
    #1;
    chk1("t4_err", m0_err_o, 1'b1);
    chk1("t4_timeout", timeout_o, 1'b1);
    chk1("t4_stb_low", s_stb_o, 1'b0);
    chk1("t4_cyc_low", s_cyc_o, 1'b0);
    chk1("t4_late_ack", m0_ack_o, 1'b0);
    @(negedge wb_clk_i);
    s_ack_i = 0;
    #1;
    chk1("t4_err_pulse", m0_err_o, 1'b0);
    chk1("t4_to_pulse", timeout_o, 1'b0);
    chk1("t4_reown", s_stb_o, 1'b1);
    @(negedge wb_clk_i);
    m0_cyc_i = 0; m0_stb_i = 0;

    // ack exactly on the last watchdog cycle
    @(negedge wb_clk_i);
    m0_cyc_i = 1; m0_stb_i = 1;
    for (int k = 0; k < 7; k++) begin
      @(negedge wb_clk_i);
      #1 chk1("t5_wait_err", m0_err_o, 1'b0);
    end
    @(negedge wb_clk_i);
    s_ack_i = 1; s_dat_i = 32'h1234_5678;
    #1;
    chk1("t5_ack", m0_ack_o, 1'b1);
    chk1("t5_err", m0_err_o, 1'b0);
    chk1("t5_timeout", timeout_o, 1'b0);
    chk32("t5_dat", m0_dat_o, 32'h1234_5678);
    @(negedge wb_clk_i);
    s_ack_i = 0; s_dat_i = '0;
    #1;
    chk1("t5_no_timeout", timeout_o, 1'b0);
    chk1("t5_no_err", m0_err_o, 1'b0);
    chk2("t5_grant", grant_o, 2'b01);
    chk1("t5_stb", s_stb_o, 1'b1);
    @(negedge wb_clk_i);
    m0_cyc_i = 0; m0_stb_i = 0;

    // reset during a stalled m1 beat
    @(negedge wb_clk_i);
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h500;
    @(negedge wb_clk_i);
    #1;
    chk2("t6_m1_owns", grant_o, 2'b10);
    chk1("t6_stalled", m1_ack_o, 1'b0);
    wb_rst_i = 1'b1; m0_cyc_i = 1; m0_stb_i = 1;
    @(negedge wb_clk_i);
    s_ack_i = 1;
    #1;
    chk2("t6_grant", grant_o, 2'b00);
    chk1("t6_scyc", s_cyc_o, 1'b0);
    chk1("t6_sstb", s_stb_o, 1'b0);
    chk32("t6_sadr", s_adr_o, 32'h0);
    chk1("t6_m1ack", m1_ack_o, 1'b0);
    chk1("t6_m0ack", m0_ack_o, 1'b0);
    chk1("t6_timeout", timeout_o, 1'b0);
    wb_rst_i = 1'b0; s_ack_i = 0;
    @(negedge wb_clk_i);
    #1 chk2("t6_m0_first", grant_o, 2'b01);
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    @(negedge wb_clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_bus_arbiter_2m.md
Name: wb_bus_arbiter_2m

Overview:
- Two-master, one-slave Wishbone classic arbiter. It shares the external Wishbone slave port (AVB Ethernet MAC register/buffer space) between the Nios Qsys Wishbone bridge (m0) and the audio-stream DMA engine (m1).
- Uses round-robin grant. A grant is held for the whole CYC. A bus watchdog converts a silent slave into an ERR to the owning master.
- Sits between the Qsys wb_* pins and the MAC slave.

Parameters:
- AW, 32, address width.
- DW, 32, data width; SW = DW/8 select lanes.
- TIMEOUT, 255, cycles of STB without ACK/ERR/RTY before abort; 0 disables the watchdog.

Ports:
- wb_clk_i  in  1  bus clock
- wb_rst_i  in  1  synchronous active-high reset
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 request
- m0_adr_i  in  AW  master 0 address
- m0_sel_i  in  SW  master 0 select
- m0_dat_i  in  DW  master 0 write data
- m0_dat_o  out  DW  master 0 read data
- m0_ack_o, m0_err_o, m0_rty_o  out  1 each  master 0 termination
- m1_*  same set as m0, for master 1
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave request
- s_adr_o  out  AW  slave address
- s_sel_o  out  SW  slave select
- s_dat_o  out  DW  slave write data
- s_dat_i  in  DW  slave read data
- s_ack_i, s_err_i, s_rty_i  in  1 each  slave termination
- grant_o  out  2  one-hot current owner; 00 when idle
- timeout_o  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Clock is wb_clk_i. Reset is wb_rst_i: synchronous, active-high.
- States: IDLE, OWN0, OWN1, TO0, TO1. Registered state, combinational output mux.
- Reset, including mid-transfer: state goes to IDLE, last-owner pointer set to 1 (so m0 wins the first tie), watchdog count 0. The next cycle shows every output at 0.
- IDLE:
  - All s_* outputs are 0, all m*_ack/err/rty are 0, grant_o=00.
  - If mX_cyc_i=1, go to OWNX next cycle.
  - If both request, grant the master that is not the last owner.
  - Request-to-slave latency is exactly 1 cycle.
- OWNX:
  - s_cyc/stb/we/adr/sel/dat_o equal mX inputs combinationally.
  - mX_dat_o = s_dat_i.
  - mX_ack/err/rty_o = s_ack/err/rty_i & s_stb_o, with 0 added latency.
  - The non-owner sees ack/err/rty=0 and dat_o=0.
  - grant_o is one-hot X.
  - While mX_cyc_i=1 the grant is held, even with stb low between beats (burst/RMW atomicity).
  - When mX_cyc_i=0, set last-owner=X. Then:
    - if the other master has cyc=1, go directly to OWN(other) with no idle bubble;
    - otherwise go to IDLE.
- Watchdog (TIMEOUT>0):
  - The count clears when s_stb_o=0 or on any of s_ack_i/s_err_i/s_rty_i. Otherwise it increments each cycle.
  - When count==TIMEOUT-1 and no termination arrives that cycle, go to TOX next cycle.
  - A termination arriving on that same cycle wins; no abort.
- TOX (exactly one cycle):
  - s_cyc_o=s_stb_o=0.
  - mX_err_o=1, timeout_o=1, count cleared.
  - Next state: OWNX if mX_cyc_i=1, else apply the IDLE/handover rule above.
  - Any late slave response is ignored, because s_stb_o=0.
- Count width is clog2(TIMEOUT+1). It never wraps because it saturates at the abort.
- Never assert more than one of ack/err/rty to a master; if the slave violates this, pass ack priority > err > rty.

Decomposition:
- Package wb_arb_pkg holds:
  - the state enum (IDLE, OWN0, OWN1, TO0, TO1);
  - the master index constants M0=0, M1=1;
  - the grant-encoding function.
- Sub-module wb_arb_watchdog: counter, clear/enable inputs, expire output, TIMEOUT parameter.

Test Plan:
- Single read: m0 cyc/stb with adr=0x0000_0100, slave acks 2 cycles later with dat=0xCAFE_F00D. Expect s_cyc_o 1 cycle after m0_cyc_i, m0_ack_o coincident with s_ack_i, m0_dat_o=0xCAFE_F00D, m1_ack_o=0.
- Simultaneous request out of reset: both cyc=1. Expect grant_o=01 first; m0 drops cyc and grant_o=10 on the very next cycle (no IDLE). After m1 finishes, a repeated tie grants m0 again (round-robin alternation across 4 rounds).
- Burst hold: m1 does 4 write beats with stb gaps while m0 requests. Expect m0 never granted until m1_cyc_i=0, and s_adr_o tracks m1 beats 0x10, 0x14, 0x18, 0x1C.
- Watchdog: TIMEOUT=8, slave never responds to m0. Expect m0_err_o and timeout_o high for 1 cycle, 8 cycles after s_stb_o rose. s_stb_o=0 in that cycle; a slave ack injected then is not forwarded.
- Boundary: slave acks exactly on the cycle count==TIMEOUT-1. Expect a normal ack and no err/timeout_o.
- Mid-transfer reset: assert wb_rst_i during an m1 stalled beat. Expect all outputs 0 and grant_o=00 after the next edge, and m0 wins the first tie after reset release.
